// File: rtl/uart_tx_serializer_if.sv
// Word handshake and serial-line signals for the UART transmit engine.
interface uart_tx_serializer_if #(
    parameter int NO_OF_DATA_BITS = 7
);
    logic [NO_OF_DATA_BITS-1:0] data_in;
    logic                       data_valid;
    logic                       data_ready;
    logic                       tx_data;
    logic                       tx_busy;
    logic                       frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, tx_data, tx_busy, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, tx_data, tx_busy, frame_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: one-deep holding register feeding a start/data/parity/stop
// serialiser with its own baud-period counter; back-to-back frames have no idle gap.
module uart_tx_serializer #(
    parameter int    NO_OF_DATA_BITS = 7,
    parameter string PARITY_ENABLED  = "TRUE",
    parameter string PARITY_TYPE     = "EVEN",
    parameter string NO_OF_STOP_BITS = "2",
    parameter int    BAUD            = 2400,
    parameter int    CLOCK_IN_MHZ    = 100
) (
    input logic                  clk,
    input logic                  reset,
    uart_tx_serializer_if.slave  bus
);
    localparam int BIT_CYCLES  = (CLOCK_IN_MHZ * 1000000) / BAUD;
    localparam bit PAR_EN      = (PARITY_ENABLED == "TRUE");
    localparam bit PAR_ODD     = (PARITY_TYPE == "ODD");
    localparam int STOP_CYCLES = (NO_OF_STOP_BITS == "0")   ? 0 :
                                 (NO_OF_STOP_BITS == "1")   ? BIT_CYCLES :
                                 (NO_OF_STOP_BITS == "1.5") ? (3 * BIT_CYCLES) / 2 :
                                                              2 * BIT_CYCLES;
    localparam int CNT_W = $clog2(2 * BIT_CYCLES + 1);
    localparam int BIT_W = $clog2(NO_OF_DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'((STOP_CYCLES > 0) ? STOP_CYCLES - 1 : 0);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(NO_OF_DATA_BITS - 1);

    if (NO_OF_DATA_BITS != 6 && NO_OF_DATA_BITS != 7 && NO_OF_DATA_BITS != 8) begin : g_bad_bits
        $error("uart_tx_serializer: NO_OF_DATA_BITS must be 6, 7 or 8");
    end
    if (PARITY_ENABLED != "TRUE" && PARITY_ENABLED != "FALSE") begin : g_bad_par_en
        $error("uart_tx_serializer: PARITY_ENABLED must be TRUE or FALSE");
    end
    if (PARITY_TYPE != "EVEN" && PARITY_TYPE != "ODD") begin : g_bad_par_type
        $error("uart_tx_serializer: PARITY_TYPE must be EVEN or ODD");
    end
    if (NO_OF_STOP_BITS != "0" && NO_OF_STOP_BITS != "1" &&
        NO_OF_STOP_BITS != "1.5" && NO_OF_STOP_BITS != "2") begin : g_bad_stop
        $error("uart_tx_serializer: NO_OF_STOP_BITS must be 0, 1, 1.5 or 2");
    end
    if (BIT_CYCLES < 1) begin : g_bad_baud
        $error("uart_tx_serializer: BAUD too high for CLOCK_IN_MHZ");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [NO_OF_DATA_BITS-1:0] shift_q, shift_d;
    logic [NO_OF_DATA_BITS-1:0] hold_q, hold_d;
    logic                       hold_full_q, hold_full_d;
    logic                       par_q, par_d;
    logic                       tx_q, tx_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       period_end;
    logic                       frame_end;
    logic                       load;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        done_d      = 1'b0;
        frame_end   = 1'b0;
        load        = 1'b0;
        period_end  = (cnt_q == ((state_q == STOP) ? STOP_LAST : BIT_LAST));

        if (bus.data_valid && ready_q) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
        end

        if (state_q == IDLE || period_end) cnt_d = '0;
        else                               cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE:   if (hold_full_q) load = 1'b1;
            START:  if (period_end) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
            DATA:   if (period_end) begin
                        if (bit_q == DATA_LAST) begin
                            if (PAR_EN)                state_d   = PARITY;
                            else if (STOP_CYCLES != 0) state_d   = STOP;
                            else                       frame_end = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shift_d = shift_q >> 1;
                        end
                    end
            PARITY: if (period_end) begin
                        if (STOP_CYCLES != 0) state_d   = STOP;
                        else                  frame_end = 1'b1;
                    end
            STOP:   if (period_end) frame_end = 1'b1;
            default: state_d = IDLE;
        endcase

        // A pending word chains straight into the next start bit on the frame-ending edge.
        if (frame_end) begin
            done_d = 1'b1;
            if (hold_full_q) load    = 1'b1;
            else             state_d = IDLE;
        end

        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ PAR_ODD;
            hold_full_d = 1'b0;
            bit_d       = '0;
            cnt_d       = '0;
        end

        ready_d = !hold_full_d;
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_data    = tx_q;
    assign bus.data_ready = ready_q;
    assign bus.tx_busy    = busy_q;
    assign bus.frame_done = done_q;
endmodule
